// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
//   master : drives start/op/rs_val/rt_val, observes busy/done/div_by_zero/hi/lo
//   slave  : the multiply/divide unit itself
interface hilo_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, rs_val, rt_val,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_val, rt_val,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide unit owning the MIPS HI/LO registers.
// Handles MULT/MULTU (shift-add, LSB first) and DIV/DIVU (restoring, MSB first)
// in 33 clock edges after accept, plus single-edge MTHI/MTLO writes.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any operation in flight
//   bus     : slave side of hilo_muldiv_if (start/op/rs_val/rt_val in,
//             busy/done/div_by_zero/hi/lo out)
//
// state  | meaning
// IDLE   | waiting for a request; MTHI/MTLO are served here
// RUN    | one multiply or divide iteration per edge, ITER edges
// FIX    | sign correction and HI/LO write-back, done pulses afterwards
module hilo_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int ITER  = WIDTH
) (
   input  logic          clk,
   input  logic          reset_n,
   hilo_muldiv_if.slave  bus
);
   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // a_q: multiplicand, or dividend shifting out / quotient shifting in
   // b_q: multiplier shifting right, or fixed divisor
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   // acc_q: running product, or remainder in the upper half
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic               is_div_q, is_div_d, dz_q, dz_d;
   logic               done_q, done_d, dzo_q, dzo_d;

   logic               accept, idle;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic               qbit;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign idle   = (state_q == S_IDLE);
   assign accept = idle && bus.start && !bus.op[2];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_RUN;
         S_RUN:   if (cnt_q == LAST) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      bus.busy        = (state_q != S_IDLE);
      bus.done        = done_q;
      bus.div_by_zero = dzo_q;
      bus.hi          = hi_q;
      bus.lo          = lo_q;
   end

   // One iteration of each engine, evaluated every cycle
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b_q};
      qbit     = ~rem_diff[WIDTH];
   end

   // Sign correction; unsigned ops never set the neg flags
   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -a_q : a_q;
      rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      is_div_d = is_div_q;
      dz_d     = dz_q;
      done_d   = 1'b0;
      dzo_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               neg_a_d  = !bus.op[0] && bus.rs_val[WIDTH-1];
               neg_b_d  = !bus.op[0] && bus.rt_val[WIDTH-1];
               a_d      = neg_a_d ? -bus.rs_val : bus.rs_val;
               b_d      = neg_b_d ? -bus.rt_val : bus.rt_val;
               is_div_d = bus.op[1];
               dz_d     = bus.op[1] && (bus.rt_val == '0);
               acc_d    = '0;
               cnt_d    = '0;
            end else if (bus.start && bus.op == 3'b100) begin
               hi_d = bus.rs_val;
            end else if (bus.start && bus.op == 3'b101) begin
               lo_d = bus.rs_val;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
               // With a zero divisor every step "subtracts" 0, so the
               // remainder ends up as the dividend magnitude and rem_fix
               // restores the original rs value for HI.
               acc_d[2*WIDTH-1:WIDTH] = qbit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
               a_d = {a_q[WIDTH-2:0], qbit};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               b_d   = b_q >> 1;
            end
         end
         S_FIX: begin
            done_d = 1'b1;
            dzo_d  = dz_q;
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = dz_q ? '1 : quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         is_div_q <= 1'b0;
         dz_q     <= 1'b0;
         done_q   <= 1'b0;
         dzo_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         is_div_q <= is_div_d;
         dz_q     <= dz_d;
         done_q   <= done_d;
         dzo_q    <= dzo_d;
      end
   end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   hilo_muldiv_if #(.WIDTH(32)) bus ();

   hilo_muldiv_unit #(.WIDTH(32), .ITER(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Reference: plain 64-bit arithmetic from the architectural definitions.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint sp, sq, sr;
      logic [63:0] up;
      dz = 1'b0;
      h  = '0;
      l  = '0;
      case (o)
         3'b000: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            {h, l} = sp;
         end
         3'b001: begin
            up = {32'b0, a} * {32'b0, b};
            {h, l} = up;
         end
         3'b010, 3'b011: begin
            if (b == 0) begin
               h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (o == 3'b010) begin
               sq = longint'($signed(a)) / longint'($signed(b));
               sr = longint'($signed(a)) % longint'($signed(b));
               l = sq[31:0];
               h = sr[31:0];
            end else begin
               l = a / b;
               h = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   // Stimulus driver: issues one request and gathers what the DUT shows.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] h, output logic [31:0] l, output logic dz,
                         output int lat, output int bcnt, output logic dn_after);
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = 0;
      bcnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) bcnt++;
      end
      h = bus.hi; l = bus.lo; dz = bus.div_by_zero;
      @(posedge clk);
      #1;
      dn_after = bus.done | bus.div_by_zero;
   endtask

   task automatic test_reset();
      #1;
      tests++;
      if ({bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero} !== 67'd0) begin
         fails++;
         $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b dz=%b, need all zero",
                  bus.hi, bus.lo, bus.busy, bus.done, bus.div_by_zero);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [2:0]  ops [6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b011, 3'b010};
      logic [31:0] rss [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000};
      logic [31:0] rts [6] = '{32'hFFFF_FFFF, 32'd5, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] ehs [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd7, 32'd0};
      logic [31:0] els [6] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
      logic        edz [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [31:0] h, l;
      logic        dz, dn_after;
      int          lat, bcnt;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], rss[i], rts[i], h, l, dz, lat, bcnt, dn_after);
         tests++;
         if (lat !== 33) begin
            fails++;
            $display("FAIL dir%0d_latency: got %0d edges, need 33", i, lat);
         end
         tests++;
         if (bcnt !== 33) begin
            fails++;
            $display("FAIL dir%0d_busy_cycles: got %0d, need 33", i, bcnt);
         end
         tests++;
         if ({h, l, dz} !== {ehs[i], els[i], edz[i]}) begin
            fails++;
            $display("FAIL dir%0d_result: got hi=%h lo=%h dz=%b, need hi=%h lo=%h dz=%b",
                     i, h, l, dz, ehs[i], els[i], edz[i]);
         end
         tests++;
         if (dn_after !== 1'b0) begin
            fails++;
            $display("FAIL dir%0d_done_width: done/dz still high next cycle, need single pulse", i);
         end
      end
   endtask

   task automatic test_mthi_mtlo();
      logic [31:0] lo_before;
      logic        seen;
      lo_before = bus.lo;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b100; bus.rs_val = 32'h1234_5678; bus.rt_val = 32'h0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      tests++;
      if ({bus.hi, bus.lo, bus.busy} !== {32'h1234_5678, lo_before, 1'b0}) begin
         fails++;
         $display("FAIL mthi: got hi=%h lo=%h busy=%b, need hi=12345678 lo=%h busy=0",
                  bus.hi, bus.lo, bus.busy, lo_before);
      end
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b101; bus.rs_val = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (bus.busy || bus.done || bus.div_by_zero) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      tests++;
      if ({bus.hi, bus.lo, seen} !== {32'h1234_5678, 32'hCAFE_F00D, 1'b0}) begin
         fails++;
         $display("FAIL mtlo: got hi=%h lo=%h busy/done seen=%b, need hi=12345678 lo=cafef00d seen=0",
                  bus.hi, bus.lo, seen);
      end
   endtask

   task automatic test_undefined_op();
      logic [31:0] h0, l0;
      h0 = bus.hi; l0 = bus.lo;
      for (int k = 6; k < 8; k++) begin
         @(negedge clk);
         bus.start = 1'b1; bus.op = 3'(k); bus.rs_val = 32'h5555_AAAA; bus.rt_val = 32'h3;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         @(posedge clk);
         #1;
         tests++;
         if ({bus.hi, bus.lo, bus.busy, bus.done} !== {h0, l0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL undef_op%0d: got hi=%h lo=%h busy=%b done=%b, need hi=%h lo=%h busy=0 done=0",
                     k, bus.hi, bus.lo, bus.busy, bus.done, h0, l0);
         end
      end
   endtask

   task automatic test_busy_ignore();
      logic [31:0] h0, l0, eh, el;
      logic        edz;
      int          lat;
      model(3'b001, 32'h0001_0003, 32'h0000_0100, eh, el, edz);
      h0 = bus.hi; l0 = bus.lo;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = 32'h0001_0003; bus.rt_val = 32'h0000_0100;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b101; bus.rs_val = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.op = 3'b100; bus.rs_val = 32'hBAAD_F00D;
      @(negedge clk);
      bus.op = 3'b000; bus.rs_val = 32'h7; bus.rt_val = 32'h9;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      tests++;
      if ({bus.hi, bus.lo, bus.busy} !== {h0, l0, 1'b1}) begin
         fails++;
         $display("FAIL busy_hold: got hi=%h lo=%h busy=%b, need hi=%h lo=%h busy=1",
                  bus.hi, bus.lo, bus.busy, h0, l0);
      end
      lat = 0;
      while (!bus.done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      tests++;
      if ({bus.done, bus.hi, bus.lo} !== {1'b1, eh, el}) begin
         fails++;
         $display("FAIL busy_ignore: got done=%b hi=%h lo=%h, need done=1 hi=%h lo=%h",
                  bus.done, bus.hi, bus.lo, eh, el);
      end
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b, eh, el, h, l;
      logic        edz, dz, dn_after;
      int          lat, bcnt;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'h0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
         model(o, a, b, eh, el, edz);
         run_op(o, a, b, h, l, dz, lat, bcnt, dn_after);
         tests++;
         if ({h, l, dz, lat, bcnt, dn_after} !== {eh, el, edz, 33, 33, 1'b0}) begin
            fails++;
            $display("FAIL rand%0d op=%0d rs=%h rt=%h: got hi=%h lo=%h dz=%b lat=%0d busy=%0d tail=%b, need hi=%h lo=%h dz=%b lat=33 busy=33 tail=0",
                     i, o, a, b, h, l, dz, lat, bcnt, dn_after, eh, el, edz);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      @(negedge clk);
      bus.start = 1'b1; bus.op = 3'b001; bus.rs_val = 32'hFFFF_0001; bus.rt_val = 32'h1234_5677;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== 66'd0) begin
         fails++;
         $display("FAIL reset_mid: got hi=%h lo=%h busy=%b done=%b, need all zero",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy || bus.div_by_zero) seen = 1'b1;
      end
      tests++;
      if ({seen, bus.hi, bus.lo} !== 65'd0) begin
         fails++;
         $display("FAIL reset_abort: got activity=%b hi=%h lo=%h, need activity=0 hi=0 lo=0",
                  seen, bus.hi, bus.lo);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 3'b000; bus.rs_val = '0; bus.rt_val = '0;
      test_reset();
      test_directed();
      test_mthi_mtlo();
      test_undefined_op();
      test_busy_ignore();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
